motor_pwm_ramp: RTL
===================

# motor_pwm_ramp

Parametrised multi-channel PWM motor driver with soft-start/slew limiting, the next generation of the single-channel motor PWM stage. Each channel takes an ADC setpoint code, latches it on the `actualizar` update pulse, slews its duty cycle toward it one step per PWM period, and drives a glitch-free PWM output. Sits between the ADC/pulse generators and the motor driver pins; the duty bus feeds display and LED logic.

## Interface
- `CHANNELS`, 2, number of independent PWM channels (≥1)
- `IN_W`, 4, setpoint code width per channel
- `CNT_W`, 8, PWM resolution; must satisfy `CNT_W ≥ IN_W`
- `PRESCALE`, 392, clock cycles per PWM count tick (≥1); 100 MHz/392/255 ≈ 1 kHz PWM
- `RAMP_STEP`, 1, maximum duty change per PWM period (≥1)

- `clock_100Mhz`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `activate`  in  1  global enable; low forces all outputs off
- `actualizar`  in  1  one-cycle update strobe; latches `setpoint`
- `setpoint`  in  CHANNELS*IN_W  channel i code at `[i*IN_W +: IN_W]`
- `pwm`  out  CHANNELS  PWM output per channel
- `duty`  out  CHANNELS*CNT_W  current applied duty, channel i at `[i*CNT_W +: CNT_W]`
- `ramping`  out  CHANNELS  high while channel duty ≠ target
- `period_start`  out  1  one-cycle pulse at each PWM period boundary

## Operation
- Prescaler counts 0..PRESCALE-1; `tick` when it equals PRESCALE-1, then wraps to 0.
- Period counter `cnt` (CNT_W bits) advances on `tick`, range 0..MAX-1 where MAX = 2^CNT_W−1; wraps MAX-1 → 0. Wrap tick = period boundary.
- Target mapping: code bit-replicated MSB-first and truncated to CNT_W (4'h8 → 8'h88 = 136; 4'hF → 8'hFF; 0 → 0).
- `actualizar` high with `activate` high: all channel targets load from `setpoint`. Ignored when `activate` low.
- Per-channel FSM, evaluated at period boundaries only:
  - IDLE: `activate` low; duty = 0. Leaves to HOLD/RAMP_UP when `activate` rises.
  - RAMP_UP: duty ← min(duty + RAMP_STEP, target); → HOLD when equal.
  - RAMP_DN: duty ← max(duty − RAMP_STEP, target); → HOLD when equal.
  - HOLD: duty = target; → RAMP_UP/RAMP_DN when target changes.
  - Any state → IDLE immediately (next edge, not at boundary) when `activate` low.
- Ramp arithmetic uses CNT_W+1 bits; no wrap past 0 or MAX.
- `pwm[i]` = (`cnt` < duty[i]), registered. duty 0 → constant low; duty MAX → constant high.
- `ramping[i]` = state is RAMP_UP or RAMP_DN.
- Re-activation after IDLE starts from duty 0 with the retained target (soft start).

## Timing
- Reset (`reset` low at a rising edge): `pwm`=0, `duty`=0, `ramping`=0, `period_start`=0, prescaler=0, `cnt`=0, targets=0, all FSMs IDLE. Reset mid-period takes effect at that edge; no partial pulse afterwards.
- `actualizar` at edge t → target valid after t; earliest duty change at the next period boundary.
- Duty changes only at boundaries → no runt pulses; `pwm` reflects new duty at the first count of the new period, one cycle after the boundary.
- `period_start` high for exactly the cycle following the wrap tick.
- `actualizar` on the boundary edge itself: that boundary uses the old target; new target applies at the following boundary.
- `activate` falling: `pwm`, `duty`, `ramping` go to 0 one edge later, regardless of period position; counters keep running.
- Full swing 0→MAX with defaults: 255 periods.

## Configuration
- `MOTOR_RAMP_EN` defined: slew-limited ramp as above.
- Not defined: RAMP_UP/RAMP_DN removed; duty loads target directly at next period boundary; `ramping` tied 0; `RAMP_STEP` unused.

## Test plan
- Reset held 5 cycles with activity on inputs → all outputs 0; after release with `activate`=0, `pwm` stays 0 for 3 periods.
- PRESCALE=2, RAMP_STEP=16, `activate`=1, strobe ch0 code 4'hF → duty ch0 steps 16,32,…,240,255 on successive boundaries; `ramping[0]` falls with duty=255; `pwm[0]` constant high thereafter.
- Ch1 code 4'h8 with MOTOR_RAMP_EN undefined → duty ch1 = 136 at first boundary; `pwm[1]` high 136 of 255 counts each period.
- Strobe asserted on a boundary edge (ch0 0→4'h4) → that boundary leaves duty unchanged; ramp toward 68 starts at the next boundary.
- `activate` dropped mid-period at duty 128 → `pwm`=0, `duty`=0 next edge; reassert → ramp restarts from 0 toward retained target 128.
- Ramp down: duty 255, new code 0, RAMP_STEP=100 → 155, 55, 0; never underflows.

Source files
------------

// File: rtl/motor_pwm_ramp.sv
// motor_pwm_ramp
//   Multi-channel PWM motor driver with soft start. Each channel latches an
//   ADC setpoint code on the update strobe and expands it to a CNT_W-bit
//   target. At every PWM period boundary the applied duty moves toward that
//   target. The PWM output is a registered compare of the shared period
//   counter against the applied duty.
//
//   Optional feature macro: MOTOR_RAMP_EN
//     defined     : duty slews by at most RAMP_STEP per period (RAMP_UP/RAMP_DN states)
//     not defined : duty loads the target directly at the next boundary, ramping = 0
//
// Parameters
//   CHANNELS  number of independent channels (>=1)
//   IN_W      setpoint code width per channel
//   CNT_W     PWM resolution (CNT_W >= IN_W), period = 2^CNT_W-1 counts
//   PRESCALE  clock cycles per PWM count (>=1)
//   RAMP_STEP maximum duty change per period (>=1, ramp build only)
//
// Ports
//   clock_100Mhz  in   system clock, rising edge
//   reset         in   synchronous, active-low reset
//   activate      in   global enable, low forces all outputs off
//   actualizar    in   one-cycle strobe, latches setpoint into all targets
//   setpoint      in   channel i code at [i*IN_W +: IN_W]
//   pwm           out  PWM output per channel
//   duty          out  applied duty, channel i at [i*CNT_W +: CNT_W]
//   ramping       out  channel is slewing toward its target
//   period_start  out  one-cycle pulse after each period boundary

module motor_pwm_ramp #(
  parameter int CHANNELS  = 2,
  parameter int IN_W      = 4,
  parameter int CNT_W     = 8,
  parameter int PRESCALE  = 392,
  parameter int RAMP_STEP = 1
) (
  input  logic                      clock_100Mhz,
  input  logic                      reset,
  input  logic                      activate,
  input  logic                      actualizar,
  input  logic [CHANNELS*IN_W-1:0]  setpoint,
  output logic [CHANNELS-1:0]       pwm,
  output logic [CHANNELS*CNT_W-1:0] duty,
  output logic [CHANNELS-1:0]       ramping,
  output logic                      period_start
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  // Last count of a period is MAX-1 = 2^CNT_W - 2, i.e. all ones but the LSB.
  localparam logic [CNT_W-1:0] CNT_LAST = ~(CNT_W'(1));

`ifdef MOTOR_RAMP_EN
  localparam longint MAX_V = (longint'(1) << CNT_W) - 1;
  // A step larger than the full scale behaves like a full-scale step; the
  // clamp keeps the CNT_W+1 bit ramp arithmetic from wrapping.
  localparam logic [CNT_W:0] STEP =
    (CNT_W+1)'((longint'(RAMP_STEP) > MAX_V) ? MAX_V : longint'(RAMP_STEP));

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_RAMP_UP = 2'd2,
    S_RAMP_DN = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1
  } state_t;
`endif

  logic [PS_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             period_start_q, period_start_d;
  logic             tick, boundary;

  logic [CNT_W-1:0] target_q [CHANNELS];
  logic [CNT_W-1:0] target_d [CHANNELS];
  logic [CNT_W-1:0] duty_q   [CHANNELS];
  logic [CNT_W-1:0] duty_d   [CHANNELS];
  state_t           state_q  [CHANNELS];
  state_t           state_d  [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;

  // Expand a setpoint code by repeating its bits MSB-first across the duty
  // width, so full-scale code maps to full-scale duty (4'hF -> 8'hFF).
  function automatic logic [CNT_W-1:0] expand_code(input logic [IN_W-1:0] code);
    logic [CNT_W-1:0] r;
    r = '0;
    for (int j = 0; j < CNT_W; j++) begin
      r[CNT_W-1-j] = code[IN_W-1-(j % IN_W)];
    end
    return r;
  endfunction

`ifdef MOTOR_RAMP_EN
  // One slew step from cur toward tgt, saturating at the target so the
  // duty never overshoots, underflows below 0 or wraps past MAX.
  function automatic logic [CNT_W-1:0] step_toward(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] tgt);
    logic [CNT_W:0] d;
    logic [CNT_W:0] t;
    logic [CNT_W:0] r;
    d = {1'b0, cur};
    t = {1'b0, tgt};
    if (d < t) begin
      r = d + STEP;
      if (r > t) r = t;
    end else if (d < t + STEP) begin
      r = t;
    end else begin
      r = d - STEP;
    end
    return r[CNT_W-1:0];
  endfunction
`endif

  // Shared timebase: prescaler produces count ticks, the period counter
  // wraps at MAX-1, and that wrap tick is the period boundary.
  always_comb begin
    tick           = (presc_q == PS_LAST);
    boundary       = tick && (cnt_q == CNT_LAST);
    presc_d        = tick ? '0 : presc_q + 1'b1;
    cnt_d          = cnt_q;
    if (tick) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
    period_start_d = boundary;
  end

  // Per-channel next state. Duty only moves at a boundary, so each PWM
  // period is drawn with a single duty value and no runt pulses appear.
  // Dropping activate bypasses the boundary and idles the channel at once.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      target_d[i] = target_q[i];
      duty_d[i]   = duty_q[i];
      state_d[i]  = state_q[i];
      pwm_d[i]    = activate && (cnt_q < duty_q[i]);

      if (activate && actualizar) begin
        target_d[i] = expand_code(setpoint[i*IN_W +: IN_W]);
      end

      if (!activate) begin
        duty_d[i]  = '0;
        state_d[i] = S_IDLE;
      end else if (boundary) begin
`ifdef MOTOR_RAMP_EN
        // Leaving IDLE always starts from zero duty (soft start).
        if (state_q[i] == S_IDLE) begin
          duty_d[i] = step_toward('0, target_q[i]);
        end else begin
          duty_d[i] = step_toward(duty_q[i], target_q[i]);
        end
        if (duty_d[i] == target_q[i]) begin
          state_d[i] = S_HOLD;
        end else if (duty_d[i] < target_q[i]) begin
          state_d[i] = S_RAMP_UP;
        end else begin
          state_d[i] = S_RAMP_DN;
        end
`else
        if (state_q[i] == S_IDLE || duty_q[i] != target_q[i]) begin
          duty_d[i] = target_q[i];
        end
        state_d[i] = S_HOLD;
`endif
      end
    end
  end

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
      pwm_q          <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        target_q[i] <= '0;
        duty_q[i]   <= '0;
        state_q[i]  <= S_IDLE;
      end
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
      pwm_q          <= pwm_d;
      for (int i = 0; i < CHANNELS; i++) begin
        target_q[i] <= target_d[i];
        duty_q[i]   <= duty_d[i];
        state_q[i]  <= state_d[i];
      end
    end
  end

  always_comb begin
    duty    = '0;
    ramping = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      duty[i*CNT_W +: CNT_W] = duty_q[i];
`ifdef MOTOR_RAMP_EN
      ramping[i] = (state_q[i] == S_RAMP_UP) || (state_q[i] == S_RAMP_DN);
`endif
    end
  end

  assign pwm          = pwm_q;
  assign period_start = period_start_q;

endmodule
